// File: rtl/bcd_binario_pkg.sv
// bcd_pkg: shared constants, FSM state encodings and the BCD validity helper
// used by the bcd_binario converter.
//   NUM_DIGITOS / LARGURA_BCD : three packed BCD digits, 12 bits
//   LARGURA_BIN               : 8-bit binary result
//   N_SHIFTS                  : one shift per result bit
//   IDLE / SHIFT / DONE       : FSM state encodings
package bcd_pkg;

  localparam int NUM_DIGITOS = 3;
  localparam int LARGURA_BCD = 12;
  localparam int LARGURA_BIN = 8;
  localparam int N_SHIFTS    = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // True when every nibble of the packed BCD word is a decimal digit (0-9).
  function automatic logic bcd_valido(input logic [LARGURA_BCD-1:0] valor);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_DIGITOS; i++) begin
      if (valor[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_binario_corretor.sv
// corretor_digito: per-digit correction step of reverse double-dabble.
// After a right shift a digit that reads 8 or more received a borrowed bit
// worth 8 from the next digit up, but that bit was really worth 5 in decimal
// terms; subtracting 3 restores a proper BCD digit.
//   d_in  : 4-bit digit after the shift
//   d_out : corrected digit
module corretor_digito (
  input  logic [3:0] d_in,
  output logic [3:0] d_out
);

  assign d_out = (d_in >= 4'd8) ? (d_in - 4'd3) : d_in;

endmodule

// File: rtl/bcd_binario.sv
// bcd_binario: sequential 3-digit packed BCD (000-255) to 8-bit binary
// converter using reverse double-dabble, one shift per clock.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   start   : conversion request, sampled only while idle
//   bcd_in  : {hundreds, tens, units} packed BCD
//   binario : result, held until a new result is produced
//   busy    : high whenever the FSM is not idle
//   done    : one-cycle pulse when binario/erro are valid
//   erro    : invalid input flag of the last conversion
// Optional feature: define BCD_BIN_CHECK_EN to build the input digit check
// and the >255 overflow check; otherwise erro is tied low and overflowing
// values return value mod 256.
module bcd_binario
  import bcd_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LARGURA_BCD-1:0] bcd_in,
  output logic [LARGURA_BIN-1:0] binario,
  output logic                   busy,
  output logic                   done,
  output logic                   erro
);

  logic [1:0]             state;
  logic [LARGURA_BCD-1:0] bcd_reg;
  logic [LARGURA_BIN-1:0] bin_reg;
  logic [LARGURA_BIN-1:0] binario_reg;
  logic [2:0]             cnt;

  logic [LARGURA_BCD-1:0] shifted_bcd;
  logic [LARGURA_BIN-1:0] shifted_bin;
  logic [LARGURA_BCD-1:0] corrigido;

  // The {bcd_reg, bin_reg} pair shifts right as one word: the LSB of the
  // BCD part falls into the MSB of the binary part.
  assign shifted_bcd = {1'b0, bcd_reg[LARGURA_BCD-1:1]};
  assign shifted_bin = {bcd_reg[0], bin_reg[LARGURA_BIN-1:1]};

  for (genvar g = 0; g < NUM_DIGITOS; g++) begin : g_corretor
    corretor_digito u_corretor (
      .d_in  (shifted_bcd[4*g +: 4]),
      .d_out (corrigido[4*g +: 4])
    );
  end

`ifdef BCD_BIN_CHECK_EN
  logic erro_reg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bcd_reg     <= '0;
      bin_reg     <= '0;
      binario_reg <= '0;
      cnt         <= '0;
`ifdef BCD_BIN_CHECK_EN
      erro_reg    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bcd_reg <= bcd_in;
            bin_reg <= '0;
            cnt     <= '0;
`ifdef BCD_BIN_CHECK_EN
            // Non-decimal digits skip the shifting entirely.
            if (!bcd_valido(bcd_in)) begin
              state       <= DONE;
              binario_reg <= '0;
              erro_reg    <= 1'b1;
            end else begin
              state <= SHIFT;
            end
`else
            state <= SHIFT;
`endif
          end
        end
        SHIFT: begin
          bcd_reg <= corrigido;
          bin_reg <= shifted_bin;
          cnt     <= cnt + 3'd1;
          if (cnt == 3'(N_SHIFTS - 1)) begin
            state <= DONE;
`ifdef BCD_BIN_CHECK_EN
            // Anything left in the BCD part after eight shifts is the
            // multiple of 256 that did not fit the result.
            if (corrigido != '0) begin
              binario_reg <= '0;
              erro_reg    <= 1'b1;
            end else begin
              binario_reg <= shifted_bin;
              erro_reg    <= 1'b0;
            end
`else
            binario_reg <= shifted_bin;
`endif
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign binario = binario_reg;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

`ifdef BCD_BIN_CHECK_EN
  assign erro = erro_reg;
`else
  assign erro = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_binario.sv
// tb_bcd_binario: self-checking bench for bcd_binario. Directed cases plus
// random BCD values compared against a decimal arithmetic reference model.
// Honours BCD_BIN_CHECK_EN the same way the design does.
module tb_bcd_binario;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] bcd_in;
  logic [7:0]  binario;
  logic        busy;
  logic        done;
  logic        erro;

  int checks;
  int errors;

  bcd_binario dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .binario (binario),
    .busy    (busy),
    .done    (done),
    .erro    (erro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference model: plain decimal arithmetic on the digits.
  task automatic modelo(input logic [11:0] bcd, output logic [7:0] exp_bin,
                        output logic exp_erro, output int exp_lat);
    int c, d, u, valor;
    bit invalido;
    c = int'(bcd[11:8]);
    d = int'(bcd[7:4]);
    u = int'(bcd[3:0]);
    valor = 100 * c + 10 * d + u;
    invalido = (c > 9) || (d > 9) || (u > 9);
    exp_lat = 8;
`ifdef BCD_BIN_CHECK_EN
    if (invalido) begin
      exp_bin = 8'h00; exp_erro = 1'b1; exp_lat = 0;
    end else if (valor > 255) begin
      exp_bin = 8'h00; exp_erro = 1'b1;
    end else begin
      exp_bin = 8'(valor); exp_erro = 1'b0;
    end
`else
    exp_bin = 8'(valor % 256);
    exp_erro = 1'b0;
    if (invalido) exp_lat = 8;
`endif
  endtask

  // Counts edges after the start edge until done is seen (bounded).
  task automatic waitDone(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Full conversion: start at edge T, check latency, result and the
  // return to idle after the single DONE cycle.
  task automatic applyStimulus(input logic [11:0] bcd, input string tag);
    logic [7:0] exp_bin;
    logic exp_erro;
    int exp_lat, lat;
    modelo(bcd, exp_bin, exp_erro, exp_lat);
    @(negedge clk);
    start = 1'b1;
    bcd_in = bcd;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    waitDone(lat);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_bin"}, 32'(binario), 32'(exp_bin));
    checkOutput({tag, "_erro"}, 32'(erro), 32'(exp_erro));
    @(posedge clk); #1;
    checkOutput({tag, "_idle"}, 32'({busy, done}), 32'd0);
    checkOutput({tag, "_hold"}, 32'(binario), 32'(exp_bin));
  endtask

  initial begin
    int lat;
    logic [11:0] r;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    start = 1'b0;
    bcd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outs", 32'({binario, busy, done, erro}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(12'h255, "d255");
    applyStimulus(12'h000, "d000");
    applyStimulus(12'h128, "d128");
    applyStimulus(12'h099, "d099");
    applyStimulus(12'h256, "d256");
    applyStimulus(12'h299, "d299");
`ifdef BCD_BIN_CHECK_EN
    applyStimulus(12'h1A3, "d1A3");
`endif

    // Start re-asserted mid-conversion must be ignored.
    @(negedge clk);
    start = 1'b1;
    bcd_in = 12'h200;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    bcd_in = 12'h001;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 3;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("ign_lat", 32'(lat), 32'd8);
    checkOutput("ign_bin", 32'(binario), 32'h0C8);
    @(posedge clk); #1;
    checkOutput("ign_idle", 32'({busy, done}), 32'd0);

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk);
    start = 1'b1;
    bcd_in = 12'h255;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_async", 32'({binario, busy, done, erro}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) lat++;
    end
    checkOutput("rst_nodone", 32'(lat), 32'd0);
    applyStimulus(12'h042, "d042");

    // Random digits; invalid digits only where the check logic exists.
    for (int i = 0; i < 40; i++) begin
`ifdef BCD_BIN_CHECK_EN
      r = 12'($urandom_range(0, 4095));
      if (i % 3 != 0) begin
        r[11:8] = 4'($urandom_range(0, 2));
        r[7:4]  = 4'($urandom_range(0, 9));
        r[3:0]  = 4'($urandom_range(0, 9));
      end
`else
      r[11:8] = 4'($urandom_range(0, 9));
      r[7:4]  = 4'($urandom_range(0, 9));
      r[3:0]  = 4'($urandom_range(0, 9));
      if (i % 2 == 0) r[11:8] = 4'($urandom_range(0, 2));
`endif
      applyStimulus(r, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
